two_bit_comp: RTL and testbench



---
 rtl/two_bit_comp_pkg.sv | 39 +++
 rtl/two_bit_comp_core.sv | 31 +++
 rtl/two_bit_comp.sv | 51 +++++
 tb/tb_two_bit_comp.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/two_bit_comp_pkg.sv
// Shared types and compare helpers for the 2-bit magnitude comparator.
// Optional cascade-in support is enabled by defining CMP_CASCADE_EN.
package two_bit_comp_pkg;

    localparam int CMP_W = 2;

    typedef enum logic [1:0] {
        CMP_GT,
        CMP_LT,
        CMP_EQ
    } cmp_res_t;

    // MSB decides unless the MSBs match, then the LSB decides.
    function automatic cmp_res_t cmp2(input logic [CMP_W-1:0] x, input logic [CMP_W-1:0] y);
        logic gt;
        logic lt;
        gt = (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
        lt = (~x[1] & y[1]) | (~(x[1] ^ y[1]) & ~x[0] & y[0]);
        if (gt) begin
            return CMP_GT;
        end else if (lt) begin
            return CMP_LT;
        end else begin
            return CMP_EQ;
        end
    endfunction

    // Returns the one-hot flag vector {g, l, e}.
    function automatic logic [2:0] res_to_flags(input cmp_res_t res);
        logic [2:0] flags;
        case (res)
            CMP_GT:  flags = 3'b100;
            CMP_LT:  flags = 3'b010;
            default: flags = 3'b001;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/two_bit_comp_core.sv
// Combinational compare element: operand bits (and cascade-in when
// CMP_CASCADE_EN is defined) to next-state g/l/e flags.
module two_bit_comp_core
    import two_bit_comp_pkg::*;
(
    input  logic x1,
    input  logic y1,
    input  logic x0,
    input  logic y0,
`ifdef CMP_CASCADE_EN
    input  logic gi,
    input  logic li,
    input  logic ei,
`endif
    output logic g_nxt,
    output logic l_nxt,
    output logic e_nxt
);

    logic [2:0] loc_flags;

    assign loc_flags = res_to_flags(cmp2({x1, x0}, {y1, y0}));

`ifdef CMP_CASCADE_EN
    // Equal operands defer to the less-significant stage.
    assign {g_nxt, l_nxt, e_nxt} = loc_flags[0] ? {gi, li, ei} : loc_flags;
`else
    assign {g_nxt, l_nxt, e_nxt} = loc_flags;
`endif

endmodule

// File: rtl/two_bit_comp.sv
// Registered 2-bit unsigned magnitude comparator with one-hot g/l/e flags.
// Define CMP_CASCADE_EN to add gi/li/ei cascade inputs for wider compares.
module two_bit_comp
    import two_bit_comp_pkg::*;
#(
    parameter logic RST_EQ_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic x1,
    input  logic y1,
    input  logic x0,
    input  logic y0,
`ifdef CMP_CASCADE_EN
    input  logic gi,
    input  logic li,
    input  logic ei,
`endif
    output logic g,
    output logic l,
    output logic e
);

    logic g_nxt;
    logic l_nxt;
    logic e_nxt;

    two_bit_comp_core u_core (
        .x1    (x1),
        .y1    (y1),
        .x0    (x0),
        .y0    (y0),
`ifdef CMP_CASCADE_EN
        .gi    (gi),
        .li    (li),
        .ei    (ei),
`endif
        .g_nxt (g_nxt),
        .l_nxt (l_nxt),
        .e_nxt (e_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            {g, l, e} <= {2'b00, RST_EQ_VAL};
        end else begin
            {g, l, e} <= {g_nxt, l_nxt, e_nxt};
        end
    end

endmodule

// File: tb/tb_two_bit_comp.sv
// Directed-vector bench for two_bit_comp; cascade vectors run only when
// CMP_CASCADE_EN is defined.
module tb_two_bit_comp;

    localparam logic RST_EQ = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic x1 = 1'b0;
    logic y1 = 1'b0;
    logic x0 = 1'b0;
    logic y0 = 1'b0;
    logic gi = 1'b0;
    logic li = 1'b0;
    logic ei = 1'b1;
    logic g;
    logic l;
    logic e;

    int n_checks = 0;
    int n_errors = 0;

    // Expected {g,l,e} for index {x1,x0,y1,y0}, hand-computed.
    logic [2:0] sweep_exp [16] = '{
        3'b001, 3'b010, 3'b010, 3'b010,
        3'b100, 3'b001, 3'b010, 3'b010,
        3'b100, 3'b100, 3'b001, 3'b010,
        3'b100, 3'b100, 3'b100, 3'b001
    };

    always #5 clk = ~clk;

    two_bit_comp #(.RST_EQ_VAL(RST_EQ)) dut (
        .clk (clk),
        .rst (rst),
        .x1  (x1),
        .y1  (y1),
        .x0  (x0),
        .y0  (y0),
`ifdef CMP_CASCADE_EN
        .gi  (gi),
        .li  (li),
        .ei  (ei),
`endif
        .g   (g),
        .l   (l),
        .e   (e)
    );

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] x, input logic [1:0] y);
        {x1, x0} = x;
        {y1, y0} = y;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] idx;

        // Reset held for two cycles with arbitrary operands.
        drive(2'b11, 2'b00);
        tick();
        check("rst_cyc1", {g, l, e}, {2'b00, RST_EQ});
        drive(2'b00, 2'b10);
        tick();
        check("rst_cyc2", {g, l, e}, {2'b00, RST_EQ});

        rst = 1'b0;
        drive(2'b01, 2'b01);
        tick();
        check("rst_release_eq", {g, l, e}, 3'b001);

        // Outputs must not follow inputs before the next edge.
        drive(2'b11, 2'b00);
        #2;
        check("no_comb_path", {g, l, e}, 3'b001);

        // All 16 operand combinations, one per cycle.
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            drive(idx[3:2], idx[1:0]);
            tick();
            check($sformatf("sweep_x%0d_y%0d", idx[3:2], idx[1:0]), {g, l, e}, sweep_exp[i]);
            check("onehot", {2'b00, $onehot({g, l, e})}, 3'b001);
        end

        // Back-to-back opposite results, no bubble.
        drive(2'b11, 2'b00);
        tick();
        check("lat_gt", {g, l, e}, 3'b100);
        drive(2'b00, 2'b11);
        tick();
        check("lat_lt", {g, l, e}, 3'b010);

        // Mid-stream reset discards the in-flight compare.
        drive(2'b11, 2'b01);
        tick();
        check("stream_gt", {g, l, e}, 3'b100);
        rst = 1'b1;
        drive(2'b10, 2'b01);
        tick();
        check("mid_rst", {g, l, e}, {2'b00, RST_EQ});
        rst = 1'b0;
        drive(2'b00, 2'b10);
        tick();
        check("post_rst_lt", {g, l, e}, 3'b010);

        // MSB dominates LSB.
        drive(2'b10, 2'b01);
        tick();
        check("msb_gt", {g, l, e}, 3'b100);
        drive(2'b01, 2'b10);
        tick();
        check("msb_lt", {g, l, e}, 3'b010);

`ifdef CMP_CASCADE_EN
        drive(2'b10, 2'b10);
        gi = 1'b1; li = 1'b0; ei = 1'b0;
        tick();
        check("casc_eq_gi", {g, l, e}, 3'b100);
        drive(2'b10, 2'b10);
        gi = 1'b0; li = 1'b1; ei = 1'b0;
        tick();
        check("casc_eq_li", {g, l, e}, 3'b010);
        drive(2'b11, 2'b01);
        gi = 1'b0; li = 1'b1; ei = 1'b0;
        tick();
        check("casc_local_wins", {g, l, e}, 3'b100);
        drive(2'b00, 2'b00);
        gi = 1'b0; li = 1'b0; ei = 1'b1;
        tick();
        check("casc_lsb_tie", {g, l, e}, 3'b001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
